// File: rtl/core_pkg.sv
// Shared constants, funct3 codes and forwarding types for the RV32I pipeline.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 bit that selects SUB over ADD and SRA over SRL.
  localparam int F7_ALT_BIT = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  function automatic logic raw_hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs2
  );
    return we && (rd != {REG_ADDR_W{1'b0}}) &&
           ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Operand forwarding for one EX source: picks MEM over WB over captured data.
module operand_fwd
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  fwd_en,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  output logic [XLEN-1:0]       fwd_data
);

  fwd_sel_t sel_s;
  logic     rs_live_s;

  // x0 is hardwired zero, so it never takes a forwarded value.
  always_comb begin
    sel_s     = FWD_RF;
    rs_live_s = fwd_en && (rs_addr != {REG_ADDR_W{1'b0}});
    if (rs_live_s && mem_reg_write && (mem_rd == rs_addr)) begin
      sel_s = FWD_MEM;
    end else if (rs_live_s && wb_reg_write && (wb_rd == rs_addr)) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  always_comb begin
    case (sel_s)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      FWD_RF:  fwd_data = rf_data;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard handling. Define ID_EX_FWD_EN for
// MEM/WB forwarding; without it every RAW match against EX/MEM/WB stalls decode.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [6:0]            id_funct7,
  input  logic [2:0]            id_funct3,
  input  logic                  id_op_imm,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  ex_valid,
  output logic [6:0]            ex_funct7,
  output logic [2:0]            ex_funct3,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read
);

  logic                  ex_valid_q,     ex_valid_d;
  logic [6:0]            ex_funct7_q,    ex_funct7_d;
  logic [2:0]            ex_funct3_q,    ex_funct3_d;
  logic                  ex_op_imm_q,    ex_op_imm_d;
  logic [REG_ADDR_W-1:0] ex_rs1_addr_q,  ex_rs1_addr_d;
  logic [REG_ADDR_W-1:0] ex_rs2_addr_q,  ex_rs2_addr_d;
  logic [XLEN-1:0]       ex_a_data_q,    ex_a_data_d;
  logic [XLEN-1:0]       ex_b_data_q,    ex_b_data_d;
  logic [REG_ADDR_W-1:0] ex_rd_addr_q,   ex_rd_addr_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_mem_read_q,  ex_mem_read_d;

  logic load_use_s;
  logic hazard_s;
  logic fwd_en_s;

`ifdef ID_EX_FWD_EN
  assign fwd_en_s = 1'b1;
`else
  assign fwd_en_s = 1'b0;
`endif

  // RAW hazards on the decode offer; rs2 is only a source for register-register ops.
  always_comb begin
    load_use_s = raw_hit(ex_valid_q && ex_mem_read_q, ex_rd_addr_q,
                         id_rs1_addr, id_rs2_addr, !id_op_imm);
`ifdef ID_EX_FWD_EN
    hazard_s = load_use_s;
`else
    hazard_s = load_use_s
            || raw_hit(ex_valid_q && ex_reg_write_q, ex_rd_addr_q,
                       id_rs1_addr, id_rs2_addr, !id_op_imm)
            || raw_hit(mem_reg_write, mem_rd, id_rs1_addr, id_rs2_addr, !id_op_imm)
            || raw_hit(wb_reg_write, wb_rd, id_rs1_addr, id_rs2_addr, !id_op_imm);
`endif
  end

  assign id_ready = !ex_stall && !hazard_s;

  // Next EX contents: flush beats stall beats bubble beats capture.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_funct7_d    = ex_funct7_q;
    ex_funct3_d    = ex_funct3_q;
    ex_op_imm_d    = ex_op_imm_q;
    ex_rs1_addr_d  = ex_rs1_addr_q;
    ex_rs2_addr_d  = ex_rs2_addr_q;
    ex_a_data_d    = ex_a_data_q;
    ex_b_data_d    = ex_b_data_q;
    ex_rd_addr_d   = ex_rd_addr_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    if (flush) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else if (ex_stall) begin
      ex_valid_d     = ex_valid_q;
    end else if (hazard_s) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      // Only shifts use funct7 among immediate ops; clearing it keeps ADDI from becoming SUB.
      ex_funct7_d    = (id_op_imm && (id_funct3 != F3_SR)) ? 7'b0000000 : id_funct7;
      ex_funct3_d    = id_funct3;
      ex_op_imm_d    = id_op_imm;
      ex_rs1_addr_d  = id_rs1_addr;
      ex_rs2_addr_d  = id_rs2_addr;
      ex_a_data_d    = id_rs1_data;
      ex_b_data_d    = id_op_imm ? id_imm : id_rs2_data;
      ex_rd_addr_d   = id_rd_addr;
      ex_reg_write_d = id_reg_write && id_valid;
      ex_mem_read_d  = id_mem_read && id_valid;
    end
  end

  // EX register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_funct7_q    <= 7'b0000000;
      ex_funct3_q    <= 3'b000;
      ex_op_imm_q    <= 1'b0;
      ex_rs1_addr_q  <= {REG_ADDR_W{1'b0}};
      ex_rs2_addr_q  <= {REG_ADDR_W{1'b0}};
      ex_a_data_q    <= {XLEN{1'b0}};
      ex_b_data_q    <= {XLEN{1'b0}};
      ex_rd_addr_q   <= {REG_ADDR_W{1'b0}};
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_funct7_q    <= ex_funct7_d;
      ex_funct3_q    <= ex_funct3_d;
      ex_op_imm_q    <= ex_op_imm_d;
      ex_rs1_addr_q  <= ex_rs1_addr_d;
      ex_rs2_addr_q  <= ex_rs2_addr_d;
      ex_a_data_q    <= ex_a_data_d;
      ex_b_data_q    <= ex_b_data_d;
      ex_rd_addr_q   <= ex_rd_addr_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_funct7    = ex_funct7_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_rd_addr   = ex_rd_addr_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;

  // Forwarding stays live while stalled so held operands see newer results.
  operand_fwd #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .fwd_en        (fwd_en_s),
    .rs_addr       (ex_rs1_addr_q),
    .rf_data       (ex_a_data_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (ex_a)
  );

  operand_fwd #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .fwd_en        (fwd_en_s && !ex_op_imm_q),
    .rs_addr       (ex_rs2_addr_q),
    .rf_data       (ex_b_data_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .fwd_data      (ex_b)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_op_imm, id_reg_write, id_mem_read;
  logic        id_ready;
  logic [6:0]  id_funct7;
  logic [2:0]  id_funct3;
  logic [31:0] id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ex_stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rd_addr;

  int checks_cnt = 0;
  int errors_cnt = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_funct7(id_funct7), .id_funct3(id_funct3), .id_op_imm(id_op_imm), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_stall(ex_stall), .flush(flush),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 1'b0; id_op_imm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_funct7 = 7'd0; id_funct3 = 3'd0; id_imm = 32'd0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    id_rs1_data = 32'd0; id_rs2_data = 32'd0;
  endtask

  task automatic offer(input logic [6:0] f7, input logic [2:0] f3, input logic op_imm,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [31:0] rs1_d,
                       input logic [4:0] rs2, input logic [31:0] rs2_d, input logic [4:0] rd,
                       input logic is_load);
    id_valid = 1'b1; id_funct7 = f7; id_funct3 = f3; id_op_imm = op_imm; id_imm = imm;
    id_rs1_addr = rs1; id_rs1_data = rs1_d; id_rs2_addr = rs2; id_rs2_data = rs2_d;
    id_rd_addr = rd; id_reg_write = 1'b1; id_mem_read = is_load;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic we, input logic [31:0] res);
    mem_rd = rd; mem_reg_write = we; mem_result = res;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic we, input logic [31:0] res);
    wb_rd = rd; wb_reg_write = we; wb_result = res;
  endtask

  initial begin
    id_idle();
    ex_stall = 1'b0; flush = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0);
    set_wb(5'd0, 1'b0, 32'd0);
    #1 rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_rwrite", 32'(ex_reg_write), 32'd0);
    check_eq("rst_a", ex_a, 32'd0);
    check_eq("rst_ready", 32'(id_ready), 32'd1);
    rst = 1'b0;
    tick();

    // ADDI x1,x0,5 with a stray funct7 of 0x20
    offer(7'h20, 3'b000, 1'b1, 32'd5, 5'd0, 32'd0, 5'd5, 32'd0, 5'd1, 1'b0);
    #1 check_eq("addi_ready", 32'(id_ready), 32'd1);
    tick();
    check_eq("addi_valid", 32'(ex_valid), 32'd1);
    check_eq("addi_f7", 32'(ex_funct7), 32'd0);
    check_eq("addi_a", ex_a, 32'd0);
    check_eq("addi_b", ex_b, 32'd5);
    check_eq("addi_rd", 32'(ex_rd_addr), 32'd1);

    // SRAI x9,x4,3 keeps funct7
    offer(7'h20, 3'b101, 1'b1, 32'd3, 5'd4, 32'h80, 5'd3, 32'd0, 5'd9, 1'b0);
    tick();
    check_eq("srai_f7", 32'(ex_funct7), 32'h20);
    check_eq("srai_f3", 32'(ex_funct3), 32'd5);
    check_eq("srai_a", ex_a, 32'h80);
    check_eq("srai_b", ex_b, 32'd3);

    // ADD x3,x3,x2 then forwarding variants on the held operands
    offer(7'h00, 3'b000, 1'b0, 32'd0, 5'd3, 32'h33, 5'd2, 32'h44, 5'd3, 1'b0);
    tick();
    id_idle();
    set_mem(5'd3, 1'b1, 32'h11);
    set_wb(5'd3, 1'b1, 32'h22);
    #1 check_eq("fwd_mem_wins", ex_a, FWD ? 32'h11 : 32'h33);
    check_eq("fwd_b_nomatch", ex_b, 32'h44);
    id_valid = 1'b1; id_rs1_addr = 5'd3;
    #1 check_eq("raw_ready", 32'(id_ready), FWD ? 32'd1 : 32'd0);
    id_idle();
    set_mem(5'd0, 1'b1, 32'h11);
    set_wb(5'd0, 1'b1, 32'h22);
    #1 check_eq("fwd_x0", ex_a, 32'h33);
    set_mem(5'd3, 1'b0, 32'h11);
    set_wb(5'd3, 1'b1, 32'h22);
    #1 check_eq("fwd_wb", ex_a, FWD ? 32'h22 : 32'h33);
    set_mem(5'd2, 1'b1, 32'h11);
    set_wb(5'd0, 1'b0, 32'h0);
    #1 check_eq("fwd_b_mem", ex_b, FWD ? 32'h11 : 32'h44);
    set_mem(5'd0, 1'b0, 32'h0);
    tick();
    check_eq("idle_bubble", 32'(ex_valid), 32'd0);

    // LW x5 then dependent ADD x6,x5,x7
    offer(7'h00, 3'b010, 1'b1, 32'd4, 5'd1, 32'h100, 5'd4, 32'd0, 5'd5, 1'b1);
    tick();
    check_eq("lw_valid", 32'(ex_valid), 32'd1);
    check_eq("lw_memrd", 32'(ex_mem_read), 32'd1);
    offer(7'h00, 3'b000, 1'b0, 32'd0, 5'd5, 32'h5555, 5'd7, 32'h77, 5'd6, 1'b0);
    #1 check_eq("lu_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    check_eq("lu_memrd", 32'(ex_mem_read), 32'd0);
    set_mem(5'd5, 1'b1, 32'hDEAD);
`ifdef ID_EX_FWD_EN
    #1 check_eq("lu_ready2", 32'(id_ready), 32'd1);
    tick();
`else
    #1 check_eq("raw_mem_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("raw_mem_bubble", 32'(ex_valid), 32'd0);
    set_mem(5'd0, 1'b0, 32'h0);
    set_wb(5'd5, 1'b1, 32'hDEAD);
    #1 check_eq("raw_wb_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("raw_wb_bubble", 32'(ex_valid), 32'd0);
    set_wb(5'd0, 1'b0, 32'h0);
    id_rs1_data = 32'hDEAD;
    #1 check_eq("raw_clear_ready", 32'(id_ready), 32'd1);
    tick();
`endif
    check_eq("lu_add_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_add_a", ex_a, 32'hDEAD);
    check_eq("lu_add_b", ex_b, 32'h77);
    set_mem(5'd0, 1'b0, 32'h0);
    set_wb(5'd0, 1'b0, 32'h0);

    // flush together with stall and an offer
    flush = 1'b1; ex_stall = 1'b1;
    #1 check_eq("fl_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("fl_valid", 32'(ex_valid), 32'd0);
    check_eq("fl_rwrite", 32'(ex_reg_write), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // ADD x8,x4,x2 then a 3-cycle stall with an ADDI offered
    offer(7'h00, 3'b000, 1'b0, 32'd0, 5'd4, 32'hA0, 5'd2, 32'hB0, 5'd8, 1'b0);
    tick();
    check_eq("st_cap_a", ex_a, 32'hA0);
    offer(7'h00, 3'b000, 1'b1, 32'd1, 5'd0, 32'd0, 5'd1, 32'd0, 5'd9, 1'b0);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("st_ready", 32'(id_ready), 32'd0);
      tick();
      check_eq("st_valid", 32'(ex_valid), 32'd1);
      check_eq("st_rd", 32'(ex_rd_addr), 32'd8);
      check_eq("st_a", ex_a, 32'hA0);
      check_eq("st_b", ex_b, 32'hB0);
    end
    set_wb(5'd4, 1'b1, 32'h1234);
    #1 check_eq("st_wb_a", ex_a, FWD ? 32'h1234 : 32'hA0);
    wb_result = 32'h5678;
    #1 check_eq("st_wb_a2", ex_a, FWD ? 32'h5678 : 32'hA0);
    set_wb(5'd0, 1'b0, 32'h0);
    ex_stall = 1'b0;
    #1 check_eq("st_release", 32'(id_ready), 32'd1);
    tick();
    check_eq("addi9_valid", 32'(ex_valid), 32'd1);
    check_eq("addi9_b", ex_b, 32'd1);

    // asynchronous reset between edges
    id_idle();
    #2 rst = 1'b1;
    #1 check_eq("arst_valid", 32'(ex_valid), 32'd0);
    check_eq("arst_rwrite", 32'(ex_reg_write), 32'd0);
    check_eq("arst_b", ex_b, 32'd0);
    check_eq("arst_ready", 32'(id_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage RV32I core.
- Captures decoded instructions from decode and presents funct7, funct3, A and B to the execute ALU one cycle later.
- Resolves RAW hazards by forwarding from MEM and WB, or by inserting a bubble on a load-use hazard.
- Honours downstream stall and branch flush.

Parameters:
- XLEN, 32, operand/result width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  single core clock.
- rst  in  1  reset; asynchronous and active-high.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_funct7  in  7  raw funct7 field.
- id_funct3  in  3  raw funct3 field.
- id_op_imm  in  1  instruction is OP-IMM (B operand = immediate).
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source register indices.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_rd_addr  in  REG_ADDR_W  destination register index.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- ex_stall  in  1  downstream cannot advance; hold EX contents.
- flush  in  1  branch taken; kill EX contents and the decode offer.
- mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM and WB.
- mem_reg_write, wb_reg_write  in  1  write enables in MEM and WB.
- mem_result, wb_result  in  XLEN  results in MEM and WB.
- ex_valid  out  1  EX holds a live instruction.
- ex_funct7  out  7  to ALU.
- ex_funct3  out  3  to ALU.
- ex_a, ex_b  out  XLEN  forwarded ALU operands.
- ex_rd_addr  out  REG_ADDR_W  EX destination.
- ex_reg_write  out  1  EX write enable.
- ex_mem_read  out  1  EX instruction is a load.

Behaviour:
- Reset (async, rst=1): all registered fields = 0, so ex_valid=0, ex_reg_write=0, ex_mem_read=0 and ex_funct*/ex_a/ex_b=0. id_ready=1 in reset unless the load-use condition holds.
- Latency: an instruction accepted at edge N appears on ex_* after edge N; one cycle.
- Handshake: transfer when id_valid & id_ready. id_ready = ~ex_stall & ~load_use.
- load_use = ex_valid & ex_mem_read & ex_rd_addr≠0 & (ex_rd_addr==id_rs1_addr | (~id_op_imm & ex_rd_addr==id_rs2_addr)).
- Update priority at each clock edge:
  - flush: ex_valid<=0 and ex_reg_write<=0; the offered instruction is dropped.
  - ex_stall: hold all registers.
  - load_use: bubble; ex_valid, ex_reg_write and ex_mem_read <= 0.
  - otherwise: capture id_* and set ex_valid<=id_valid.
  - Write-enable qualification: ex_reg_write and ex_mem_read are captured ANDed with id_valid.
- funct7 fix-up on capture: if id_op_imm & id_funct3≠3'b101, captured funct7=0, so ADDI is never executed as SUB; SRAI/SRLI keep funct7.
- Operand select: rs2 data is captured when id_op_imm=0, the immediate when id_op_imm=1. An op_imm flag is stored.
- Forwarding (combinational on outputs), per source with stored rs index r≠0:
  - MEM match (mem_reg_write & mem_rd==r) wins over WB match (wb_reg_write & wb_rd==r).
  - Otherwise the captured register data is used.
  - ex_b is forwarded only when op_imm=0; x0 is never forwarded.
- Forwarding stays live while stalled, so held operands track newer MEM/WB results.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: no forward muxes; ex_a/ex_b = captured data. The hazard condition widens to any RAW match against EX (reg_write), MEM or WB destinations (rd≠0), each inserting a bubble until it clears.

Decomposition:
- Shared package core_pkg:
  - XLEN and REG_ADDR_W constants.
  - funct3 codes (ADD=000, SLL=001, SR=101 ...) and funct7 SUB/SRA bit index 5.
  - fwd_sel_t enum {FWD_RF, FWD_MEM, FWD_WB}.
- One natural sub-module, operand_fwd: computes fwd_sel_t and the muxed value for one source; instantiated twice.

Test Plan:
- ADDI x1,x0,5 (funct7 raw 7'h20, id_op_imm=1, funct3=000) -> next cycle ex_funct7=0, ex_a=0, ex_b=5, ex_valid=1.
- EX=ADD rd=x3; MEM holds rd=x3 result 0x11, WB holds rd=x3 result 0x22; EX rs1=x3 -> ex_a=0x11. Same case with rd=x0 -> captured RF value.
- EX=LW x5, decode ADD x6,x5,x7 -> id_ready=0 for one cycle, then ex_valid=0 (bubble), then ADD captured and, with MEM rd=x5 result 0xDEAD, ex_a=0xDEAD.
- flush=1 together with ex_stall=1 and id_valid=1 -> next cycle ex_valid=0, ex_reg_write=0.
- ex_stall held 3 cycles with id_valid=1 -> ex_* unchanged, id_ready=0; a WB result change on matching rs shows on ex_a combinationally.
- rst asserted mid-stream, asynchronously between edges -> ex_valid=0 and ex_reg_write=0 immediately, without waiting for a clock edge.
